// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch/sequencing unit:
// FSM states, branch/done opcodes and the fixed branch target table.
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    HALT = 2'd2
  } state_e;

  localparam logic [3:0] OP_BR_ALWAYS = 4'b0001;
  localparam logic [3:0] OP_BR_ZERO   = 4'b0010;
  localparam logic [3:0] OP_BR_NEG    = 4'b0011;
  localparam logic [3:0] OP_DONE      = 4'b1111;

  localparam int LUT_W = 10;

  // Branch targets are stored at the full 10-bit address width and narrowed by the user.
  function automatic logic [LUT_W-1:0] lut_target(input logic [3:0] idx);
    logic [LUT_W-1:0] t;
    case (idx)
      4'd0:    t = 10'd100;
      4'd1:    t = 10'd200;
      4'd2:    t = 10'd300;
      4'd3:    t = 10'd40;
      4'd4:    t = 10'd500;
      4'd5:    t = 10'd600;
      4'd6:    t = 10'd700;
      4'd7:    t = 10'd800;
      4'd8:    t = 10'd900;
      4'd9:    t = 10'd1000;
      4'd10:   t = 10'd16;
      4'd11:   t = 10'd32;
      4'd12:   t = 10'd64;
      4'd13:   t = 10'd128;
      4'd14:   t = 10'd256;
      4'd15:   t = 10'd1023;
      default: t = 10'd0;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/pc_lut.sv
// Combinational 16-entry branch target lookup indexed by the operand nibble.
module pc_lut
  import fetch_pkg::*;
#(
  parameter int PCW = 10
) (
  input  logic [3:0]     idx,
  output logic [PCW-1:0] target
);

  // Table lookup, sized to the program counter width.
  always_comb begin
    target = PCW'(lut_target(idx));
  end

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction fetch and sequencing: owns the PC, addresses the synchronous
// instruction ROM, splits machine words and resolves branches with no bubble.
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter int PCW = 10,
  parameter int IW  = 9
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [IW-1:0]  imem_data,
  input  logic           branch,
  input  logic           zero,
  input  logic           neg,
  output logic [PCW-1:0] imem_addr,
  output logic [3:0]     instr,
  output logic           ld_immed,
  output logic [7:0]     operand,
  output logic           instr_valid,
  output logic [PCW-1:0] pc,
  output logic           done,
  output logic [15:0]    retired
);

  state_e         state_r, state_nxt_s;
  logic [PCW-1:0] pc_r, pc_nxt_s, next_pc_s, pc_inc_s, target_s;
  logic [15:0]    retired_r, retired_nxt_s;
  logic           done_r, done_nxt_s;
  logic           cond_s, taken_s, is_done_s;

  pc_lut #(.PCW(PCW)) u_pc_lut (
    .idx    (operand[3:0]),
    .target (target_s)
  );

  // Split the machine word into opcode, load-immediate flag and operand.
  always_comb begin
    ld_immed = imem_data[8];
    if (imem_data[8]) begin
      instr   = 4'b0000;
      operand = imem_data[7:0];
    end else begin
      instr   = imem_data[7:4];
      operand = {4'b0000, imem_data[3:0]};
    end
  end

  // Branch resolution and next-PC selection for the executing word.
  always_comb begin
    case (instr)
      OP_BR_ALWAYS: cond_s = 1'b1;
      OP_BR_ZERO:   cond_s = zero;
      OP_BR_NEG:    cond_s = neg;
      default:      cond_s = 1'b0;
    endcase
    taken_s   = branch & ~ld_immed & cond_s;
    is_done_s = ~ld_immed & (instr == OP_DONE);
    pc_inc_s  = pc_r + {{(PCW-1){1'b0}}, 1'b1};
    if (taken_s) begin
      next_pc_s = target_s;
    end else begin
      next_pc_s = pc_inc_s;
    end
  end

  // Next-state, next-PC and memory address; a restart presents address 0 so the
  // first word is ready on entry to EXEC.
  always_comb begin
    state_nxt_s   = state_r;
    pc_nxt_s      = pc_r;
    retired_nxt_s = retired_r;
    done_nxt_s    = done_r;
    imem_addr     = pc_r;
    instr_valid   = 1'b0;
    case (state_r)
      IDLE: begin
        imem_addr = {PCW{1'b0}};
        if (start) begin
          state_nxt_s   = EXEC;
          pc_nxt_s      = {PCW{1'b0}};
          retired_nxt_s = 16'h0000;
          done_nxt_s    = 1'b0;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      EXEC: begin
        instr_valid = 1'b1;
        if (retired_r != 16'hFFFF) begin
          retired_nxt_s = retired_r + 16'h0001;
        end else begin
          retired_nxt_s = retired_r;
        end
        if (is_done_s) begin
          state_nxt_s = HALT;
          done_nxt_s  = 1'b1;
          imem_addr   = pc_r;
        end else begin
          imem_addr = next_pc_s;
          pc_nxt_s  = next_pc_s;
        end
      end
      HALT: begin
        if (start) begin
          state_nxt_s   = EXEC;
          imem_addr     = {PCW{1'b0}};
          pc_nxt_s      = {PCW{1'b0}};
          retired_nxt_s = 16'h0000;
          done_nxt_s    = 1'b0;
        end else begin
          imem_addr = pc_r;
        end
      end
      default: begin
        state_nxt_s = IDLE;
        imem_addr   = {PCW{1'b0}};
      end
    endcase
  end

  // State, PC, retire counter and done flag registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= IDLE;
      pc_r      <= {PCW{1'b0}};
      retired_r <= 16'h0000;
      done_r    <= 1'b0;
    end else begin
      state_r   <= state_nxt_s;
      pc_r      <= pc_nxt_s;
      retired_r <= retired_nxt_s;
      done_r    <= done_nxt_s;
    end
  end

  assign pc      = pc_r;
  assign retired = retired_r;
  assign done    = done_r;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Table-driven bench: per-program instruction records with hand-derived
// expectations are queued at start and popped on each executing cycle.
module tb_fetch_sequencer;

  typedef struct {
    int prog;
    int pc;
    int word;
    bit br;
    bit z;
    bit n;
    bit st;
    int e_instr;
    bit e_ld;
    int e_op;
    int e_next;
    bit e_done;
  } vec_t;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [8:0] imem_data;
  logic       branch;
  logic       zero;
  logic       neg;
  logic [9:0] imem_addr;
  logic [3:0] instr;
  logic       ld_immed;
  logic [7:0] operand;
  logic       instr_valid;
  logic [9:0] pc;
  logic       done;
  logic [15:0] retired;

  logic [8:0] mem [0:1023];
  vec_t tbl[$];
  vec_t sb[$];
  int n_vec;
  int n_err;

  fetch_sequencer #(.PCW(10), .IW(9)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .imem_data   (imem_data),
    .branch      (branch),
    .zero        (zero),
    .neg         (neg),
    .imem_addr   (imem_addr),
    .instr       (instr),
    .ld_immed    (ld_immed),
    .operand     (operand),
    .instr_valid (instr_valid),
    .pc          (pc),
    .done        (done),
    .retired     (retired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous instruction ROM model.
  always @(posedge clk) imem_data <= mem[imem_addr];

  function automatic vec_t mk(int prog, int pcv, int word, bit br, bit z, bit n, bit st,
                              int ei, bit el, int eo, int en, bit ed);
    vec_t v;
    v.prog = prog; v.pc = pcv; v.word = word; v.br = br; v.z = z; v.n = n; v.st = st;
    v.e_instr = ei; v.e_ld = el; v.e_op = eo; v.e_next = en; v.e_done = ed;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic run_prog(input int p, input int reset_pc);
    vec_t v;
    int k;
    int last_pc;
    int budget;
    for (int a = 0; a < 1024; a++) mem[a] = 9'h000;
    sb.delete();
    foreach (tbl[i]) begin
      if (tbl[i].prog == p) begin
        mem[tbl[i].pc] = 9'(tbl[i].word);
        sb.push_back(tbl[i]);
      end
    end
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    k = 0;
    last_pc = 0;
    budget = 0;
    while (sb.size() > 0 && budget < 200) begin
      budget++;
      start = 1'b0;
      if (instr_valid !== 1'b1) begin
        chk("instr_valid_exec", 32'(instr_valid), 32'd1);
        sb.delete();
        break;
      end
      v = sb.pop_front();
      branch = v.br; zero = v.z; neg = v.n; start = v.st;
      #1;
      chk("pc", 32'(pc), 32'(v.pc));
      chk("instr", 32'(instr), 32'(v.e_instr));
      chk("ld_immed", 32'(ld_immed), 32'(v.e_ld));
      chk("operand", 32'(operand), 32'(v.e_op));
      chk("retired_run", 32'(retired), 32'(k));
      if (k == 0) chk("done_low_on_entry", 32'(done), 32'd0);
      if (!v.e_done) chk("imem_addr_next", 32'(imem_addr), 32'(v.e_next));
      last_pc = v.pc;
      k++;
      if (v.pc == reset_pc) begin
        rst_n = 1'b0;
        #1;
        chk("rst_instr_valid", 32'(instr_valid), 32'd0);
        chk("rst_pc", 32'(pc), 32'd0);
        chk("rst_retired", 32'(retired), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_imem_addr", 32'(imem_addr), 32'd0);
        sb.delete();
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("idle_instr_valid", 32'(instr_valid), 32'd0);
        chk("idle_pc", 32'(pc), 32'd0);
        chk("idle_retired", 32'(retired), 32'd0);
        return;
      end
      @(posedge clk); #1;
    end
    start = 1'b0;
    branch = 1'b0; zero = 1'b0; neg = 1'b0;
    #1;
    chk("halt_done", 32'(done), 32'd1);
    chk("halt_instr_valid", 32'(instr_valid), 32'd0);
    chk("halt_retired", 32'(retired), 32'(k));
    chk("halt_pc", 32'(pc), 32'(last_pc));
    chk("halt_imem_addr", 32'(imem_addr), 32'(last_pc));
    @(posedge clk); #1;
    chk("halt_stays", 32'(done), 32'd1);
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst_n = 1'b0; start = 1'b0; branch = 1'b0; zero = 1'b0; neg = 1'b0;
    for (int a = 0; a < 1024; a++) mem[a] = 9'h000;

    // prog 0: straight line, field split, branch flag/opcode mismatches, done at 8
    tbl.push_back(mk(0, 0, 'h1A5, 0, 0, 0, 0, 0, 1, 'hA5, 1, 0));
    tbl.push_back(mk(0, 1, 'h083, 0, 0, 0, 0, 8, 0, 'h03, 2, 0));
    tbl.push_back(mk(0, 2, 'h043, 1, 1, 1, 0, 4, 0, 'h03, 3, 0));
    tbl.push_back(mk(0, 3, 'h013, 0, 1, 1, 0, 1, 0, 'h03, 4, 0));
    tbl.push_back(mk(0, 4, 'h061, 0, 0, 0, 0, 6, 0, 'h01, 5, 0));
    tbl.push_back(mk(0, 5, 'h07E, 0, 0, 0, 0, 7, 0, 'h0E, 6, 0));
    tbl.push_back(mk(0, 6, 'h095, 0, 0, 0, 0, 9, 0, 'h05, 7, 0));
    tbl.push_back(mk(0, 7, 'h00F, 0, 0, 0, 0, 0, 0, 'h0F, 8, 0));
    tbl.push_back(mk(0, 8, 'h0F0, 0, 0, 0, 0, 15, 0, 'h00, 8, 1));
    // prog 1: conditional branches on zero/neg through lut[3]=40
    tbl.push_back(mk(1, 0, 'h023, 1, 1, 0, 0, 2, 0, 'h03, 40, 0));
    tbl.push_back(mk(1, 40, 'h023, 1, 0, 1, 0, 2, 0, 'h03, 41, 0));
    tbl.push_back(mk(1, 41, 'h033, 1, 0, 1, 0, 3, 0, 'h03, 40, 0));
    tbl.push_back(mk(1, 40, 'h023, 0, 1, 0, 0, 2, 0, 'h03, 41, 0));
    tbl.push_back(mk(1, 41, 'h033, 1, 1, 0, 0, 3, 0, 'h03, 42, 0));
    tbl.push_back(mk(1, 42, 'h0F0, 0, 0, 0, 0, 15, 0, 'h00, 42, 1));
    // prog 2: jump to 1023, wrap to 0, start ignored in EXEC, ld-immed never branches/halts
    tbl.push_back(mk(2, 0, 'h01F, 1, 0, 0, 0, 1, 0, 'h0F, 1023, 0));
    tbl.push_back(mk(2, 1023, 'h050, 0, 0, 0, 1, 5, 0, 'h00, 0, 0));
    tbl.push_back(mk(2, 0, 'h01F, 0, 1, 1, 0, 1, 0, 'h0F, 1, 0));
    tbl.push_back(mk(2, 1, 'h11F, 1, 1, 1, 0, 0, 1, 'h1F, 2, 0));
    tbl.push_back(mk(2, 2, 'h1F0, 0, 0, 0, 0, 0, 1, 'hF0, 3, 0));
    tbl.push_back(mk(2, 3, 'h0F0, 0, 0, 0, 0, 15, 0, 'h00, 3, 1));

    repeat (2) @(posedge clk);
    #1;
    chk("reset_instr_valid", 32'(instr_valid), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_pc", 32'(pc), 32'd0);
    chk("reset_retired", 32'(retired), 32'd0);
    chk("reset_imem_addr", 32'(imem_addr), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("idle_no_start", 32'(instr_valid), 32'd0);

    run_prog(0, -1);
    run_prog(1, -1);
    run_prog(2, -1);
    run_prog(0, 5);
    run_prog(0, -1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
